// File: rtl/mvm_weight_loader.sv
// mvm_weight_loader
//   Sequencer that pushes register-file weights from a local weight memory
//   into the MVM NoC. For each destination router FIRST_DEST..FIRST_DEST+
//   NUM_DEST-1 it sends one single-beat AXI-Stream write packet per register
//   file 0..NUM_RF-1. Each beat is tagged with the RF write opcode and a
//   one-hot RF select.
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   START             one-cycle pulse that starts a load (only honoured in IDLE)
//   CFG_RF_ADDR       RF write address, captured on an accepted START
//   CFG_BCAST         1: every router gets words 0..NUM_RF-1
//                     0: router i gets words i*NUM_RF..i*NUM_RF+NUM_RF-1
//   BUSY / DONE       load in progress / one-cycle completion pulse
//   WMEM_RD_EN/ADDR   weight memory read port (data returns one cycle later
//   WMEM_RDATA        on WMEM_RDATA)
//   AXIS_M_*          AXI-Stream master toward the NoC slave port of mvm_top
module mvm_weight_loader #(
  parameter int               DATAW      = 512,
  parameter int               IDW        = 4,
  parameter int               DESTW      = 12,
  parameter int               NUM_RF     = 8,
  parameter int               USERW      = 11 + NUM_RF,
  parameter int               NUM_DEST   = 63,
  parameter logic [DESTW-1:0] FIRST_DEST = 'h001,
  parameter int               WADDRW     = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [8:0]        CFG_RF_ADDR,
  input  logic              CFG_BCAST,
  output logic              BUSY,
  output logic              DONE,
  output logic              WMEM_RD_EN,
  output logic [WADDRW-1:0] WMEM_ADDR,
  input  logic [DATAW-1:0]  WMEM_RDATA,
  output logic              AXIS_M_TVALID,
  input  logic              AXIS_M_TREADY,
  output logic [DATAW-1:0]  AXIS_M_TDATA,
  output logic [IDW-1:0]    AXIS_M_TID,
  output logic [DESTW-1:0]  AXIS_M_TDEST,
  output logic [USERW-1:0]  AXIS_M_TUSER,
  output logic              AXIS_M_TLAST
);

  localparam int RFW = (NUM_RF > 1) ? $clog2(NUM_RF) : 1;
  localparam int DSW = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [RFW-1:0]    r_rf_idx;
  logic [DSW-1:0]    r_dest_idx;
  logic [8:0]        r_cfg_addr;
  logic              r_bcast;

  logic [DATAW-1:0]  r_tdata;
  logic [DESTW-1:0]  r_tdest;
  logic [USERW-1:0]  r_tuser;

  logic              w_hs;
  logic              w_last_rf;
  logic              w_last_dest;
  logic [WADDRW-1:0] w_addr;
  logic [NUM_RF-1:0] w_sel;

  assign w_hs        = (r_state == S_SEND) && AXIS_M_TREADY;
  assign w_last_rf   = (r_rf_idx == RFW'(NUM_RF - 1));
  assign w_last_dest = (r_dest_idx == DSW'(NUM_DEST - 1));

  // Arithmetic is done at WADDRW bits on purpose: the address wraps modulo
  // the memory size rather than saturating.
  assign w_addr = WADDRW'(r_rf_idx) +
                  (r_bcast ? '0 : WADDRW'(r_dest_idx) * WADDRW'(NUM_RF));

  assign w_sel  = {{(NUM_RF-1){1'b0}}, 1'b1} << r_rf_idx;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and control outputs
  always_comb begin
    w_next        = r_state;
    BUSY          = 1'b1;
    DONE          = 1'b0;
    WMEM_RD_EN    = 1'b0;
    AXIS_M_TVALID = 1'b0;
    AXIS_M_TLAST  = 1'b0;
    case (r_state)
      S_IDLE: begin
        BUSY = 1'b0;
        if (START) w_next = S_FETCH;
      end
      S_FETCH: begin
        WMEM_RD_EN = 1'b1;
        w_next     = S_WAIT;
      end
      S_WAIT: w_next = S_SEND;
      S_SEND: begin
        AXIS_M_TVALID = 1'b1;
        AXIS_M_TLAST  = 1'b1;
        if (AXIS_M_TREADY) begin
          if (!w_last_rf)        w_next = S_FETCH;
          else if (!w_last_dest) w_next = S_GAP;
          else                   w_next = S_DONE;
        end
      end
      S_GAP:  w_next = S_FETCH;
      S_DONE: begin
        DONE   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        BUSY   = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  // Walk counters and configuration latched on an accepted START
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rf_idx   <= '0;
      r_dest_idx <= '0;
      r_cfg_addr <= '0;
      r_bcast    <= 1'b0;
    end else if (r_state == S_IDLE && START) begin
      r_rf_idx   <= '0;
      r_dest_idx <= '0;
      r_cfg_addr <= CFG_RF_ADDR;
      r_bcast    <= CFG_BCAST;
    end else if (w_hs) begin
      if (!w_last_rf) begin
        r_rf_idx <= r_rf_idx + RFW'(1);
      end else if (!w_last_dest) begin
        r_rf_idx   <= '0;
        r_dest_idx <= r_dest_idx + DSW'(1);
      end
    end
  end

  // Beat capture: memory data arrives during WAIT and is held through SEND.
  // Cleared on reset so the stream outputs read as zero while idle after reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tdata <= '0;
      r_tdest <= '0;
      r_tuser <= '0;
    end else if (r_state == S_WAIT) begin
      r_tdata <= WMEM_RDATA;
      r_tdest <= FIRST_DEST + DESTW'(r_dest_idx);
      r_tuser <= {w_sel, 2'b11, r_cfg_addr};
    end
  end

  assign WMEM_ADDR    = WMEM_RD_EN ? w_addr : '0;
  assign AXIS_M_TDATA = r_tdata;
  assign AXIS_M_TDEST = r_tdest;
  assign AXIS_M_TUSER = r_tuser;
  assign AXIS_M_TID   = '0;

endmodule
